strobe_converter: RTL and testbench

- Converts a level or arbitrary-width input into a clean, fixed-width, single-shot strobe.
- The input is optionally synchronized into the clk domain.
- A selected edge (rising, falling or both) is detected, and a registered pulse of PULSE_WIDTH cycles is emitted.
- An optional hold-off window suppresses re-triggering.
- Used wherever asynchronous or slow control levels must drive single-cycle event logic.

---
 rtl/strobe_converter.sv | 153 +++++++++++++++
 tb/tb_strobe_converter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/strobe_converter.sv
// Turns a level (optionally asynchronous) into a fixed-width single-shot strobe
// on a selected edge, with an optional re-trigger hold-off window.
module strobe_converter #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int PULSE_WIDTH = 1,
    parameter int HOLDOFF     = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_WIDTH - 1);
    localparam logic [HCW-1:0] HOLD_LOAD  = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    // Single-cycle pulses with no hold-off may chain into back-to-back strobes.
    localparam bit RETRIGGER = (PULSE_WIDTH == 1) && (HOLDOFF == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic d;
    logic d_q_reg;
    logic rise;
    logic fall;
    logic trig;

    state_t         state_reg, state_next;
    logic [PCW-1:0] pcnt_reg, pcnt_next;
    logic [HCW-1:0] hcnt_reg, hcnt_next;
    logic           out_reg, out_next;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign d = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] s_reg;
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            s_reg[gi] <= 1'b0;
                        end else begin
                            s_reg[gi] <= in;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            s_reg[gi] <= 1'b0;
                        end else begin
                            s_reg[gi] <= s_reg[gi-1];
                        end
                    end
                end
            end
            assign d = s_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q_reg <= 1'b0;
        end else begin
            d_q_reg <= d;
        end
    end

    assign rise = d & ~d_q_reg;
    assign fall = ~d & d_q_reg;

    // Unknown edge modes fall back to rising-edge detection.
    always_comb begin
        trig = rise;
        if (EDGE_MODE == 1) begin
            trig = fall;
        end else if (EDGE_MODE == 2) begin
            trig = rise | fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pcnt_reg  <= '0;
            hcnt_reg  <= '0;
            out_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pcnt_reg  <= pcnt_next;
            hcnt_reg  <= hcnt_next;
            out_reg   <= out_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pcnt_next  = pcnt_reg;
        hcnt_next  = hcnt_reg;
        out_next   = out_reg;
        case (state_reg)
            IDLE: begin
                out_next = 1'b0;
                if (trig) begin
                    out_next   = 1'b1;
                    pcnt_next  = PULSE_LOAD;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                out_next = 1'b1;
                if (pcnt_reg == '0) begin
                    out_next = 1'b0;
                    if (HOLDOFF > 0) begin
                        hcnt_next  = HOLD_LOAD;
                        state_next = HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                    // The last pulse cycle acts as IDLE so a fresh edge yields an adjacent strobe.
                    if (RETRIGGER && trig) begin
                        out_next   = 1'b1;
                        pcnt_next  = PULSE_LOAD;
                        state_next = PULSE;
                    end
                end else begin
                    pcnt_next = pcnt_reg - PCW'(1);
                end
            end
            HOLD: begin
                out_next = 1'b0;
                if (hcnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    hcnt_next = hcnt_reg - HCW'(1);
                end
            end
            default: begin
                out_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign out = out_reg;

endmodule

// File: tb/tb_strobe_converter.sv
// Scoreboard bench: four strobe_converter configurations share clk/rst_n; a cycle model
// pushes the expected outputs each clock and the negedge checker pops and compares them.
module tb_strobe_converter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic [3:0] dout;

    localparam int SYNC_P [4] = '{2, 2, 0, 2};
    localparam int MODE_P [4] = '{0, 2, 0, 0};
    localparam int PW_P   [4] = '{1, 1, 4, 1};
    localparam int HO_P   [4] = '{0, 0, 0, 3};
    string tags [4] = '{"def", "both", "pw4", "hold"};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    strobe_converter #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_WIDTH(1), .HOLDOFF(0))
        u_def  (.clk(clk), .rst_n(rst_n), .in(din[0]), .out(dout[0]));
    strobe_converter #(.SYNC_STAGES(2), .EDGE_MODE(2), .PULSE_WIDTH(1), .HOLDOFF(0))
        u_both (.clk(clk), .rst_n(rst_n), .in(din[1]), .out(dout[1]));
    strobe_converter #(.SYNC_STAGES(0), .EDGE_MODE(0), .PULSE_WIDTH(4), .HOLDOFF(0))
        u_pw4  (.clk(clk), .rst_n(rst_n), .in(din[2]), .out(dout[2]));
    strobe_converter #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_WIDTH(1), .HOLDOFF(3))
        u_hold (.clk(clk), .rst_n(rst_n), .in(din[3]), .out(dout[3]));

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: busy = cycles until edges are accepted again, on = strobe cycles left.
    logic [7:0] hist [4];
    logic       dq_m [4];
    int         busy [4];
    int         on_m [4];
    logic [3:0] exp_q [$];
    int         cyc = 0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            hist[i] = '0; dq_m[i] = 1'b0; busy[i] = 0; on_m[i] = 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hist[i] = '0; dq_m[i] = 1'b0; busy[i] = 0; on_m[i] = 0;
            end
            exp_q.delete();
        end else begin
            logic [3:0] e;
            e = '0;
            for (int i = 0; i < 4; i++) begin
                logic x, d, r, f, t;
                bit   acc;
                x = din[i];
                if (SYNC_P[i] == 0) d = x;
                else d = hist[i][SYNC_P[i]-1];
                r = d & ~dq_m[i];
                f = ~d & dq_m[i];
                t = (MODE_P[i] == 1) ? f : (MODE_P[i] == 2) ? (r | f) : r;
                acc = (busy[i] == 0) || (PW_P[i] == 1 && HO_P[i] == 0 && busy[i] == 1);
                if (acc && t) begin
                    busy[i] = PW_P[i] + HO_P[i];
                    on_m[i] = PW_P[i];
                end else begin
                    if (busy[i] > 0) busy[i]--;
                    if (on_m[i] > 0) on_m[i]--;
                end
                hist[i] = {hist[i][6:0], x};
                dq_m[i] = d;
                e[i] = (on_m[i] > 0);
            end
            exp_q.push_back(e);
        end
    end

    int high_cnt  [4] = '{0, 0, 0, 0};
    int rise_cnt  [4] = '{0, 0, 0, 0};
    int last_rise [4] = '{-1, -1, -1, -1};
    logic prev_o  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int min_gap3 = 1000;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) check_val(tags[i], int'(dout[i]), 0);
        end else if (exp_q.size() == 0) begin
            check_val("exp_queue_depth", exp_q.size(), 1);
        end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            for (int i = 0; i < 4; i++) check_val(tags[i], int'(dout[i]), int'(e[i]));
        end
        for (int i = 0; i < 4; i++) begin
            if (dout[i]) begin
                high_cnt[i]++;
                if (!prev_o[i]) begin
                    rise_cnt[i]++;
                    if (i == 3 && last_rise[i] >= 0 && (cyc - last_rise[i]) < min_gap3)
                        min_gap3 = cyc - last_rise[i];
                    last_rise[i] = cyc;
                    $display("[%0t] %s strobe at cycle %0d", $time, tags[i], cyc);
                end
            end
            prev_o[i] = dout[i];
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int r0, h0, c0;

    initial begin
        rst_n = 1'b0;
        din   = '0;
        step(3);
        rst_n = 1'b1;
        step(2);

        // Two-cycle input level on the default configuration.
        r0 = rise_cnt[0]; h0 = high_cnt[0]; c0 = cyc;
        din[0] = 1'b1; step(2); din[0] = 1'b0; step(8);
        check_val("def_strobes", rise_cnt[0] - r0, 1);
        check_val("def_width", high_cnt[0] - h0, 1);
        check_val("def_latency", last_rise[0] - c0, 3);

        // Both-edge mode: long level, then a one-cycle level giving adjacent strobes.
        r0 = rise_cnt[1]; h0 = high_cnt[1];
        din[1] = 1'b1; step(5); din[1] = 1'b0; step(8);
        check_val("both_strobes", rise_cnt[1] - r0, 2);
        check_val("both_width", high_cnt[1] - h0, 2);
        r0 = rise_cnt[1]; h0 = high_cnt[1];
        din[1] = 1'b1; step(1); din[1] = 1'b0; step(8);
        check_val("b2b_runs", rise_cnt[1] - r0, 1);
        check_val("b2b_high", high_cnt[1] - h0, 2);

        // Four-cycle pulse with no synchronizer.
        r0 = rise_cnt[2]; h0 = high_cnt[2]; c0 = cyc;
        din[2] = 1'b1; step(3); din[2] = 1'b0; step(8);
        check_val("pw4_strobes", rise_cnt[2] - r0, 1);
        check_val("pw4_width", high_cnt[2] - h0, 4);
        check_val("pw4_latency", last_rise[2] - c0, 1);

        // Hold-off drops every other rising edge when toggling every 2 cycles.
        r0 = rise_cnt[3];
        for (int k = 0; k < 6; k++) begin
            din[3] = 1'b1; step(2); din[3] = 1'b0; step(2);
        end
        step(10);
        check_val("hold_strobes", rise_cnt[3] - r0, 3);
        check_val("hold_gap_ok", int'(min_gap3 >= 4), 1);

        // Asynchronous reset in the second cycle of a 4-cycle pulse.
        din[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_val("pw4_pre_rst", int'(dout[2]), 1);
        rst_n = 1'b0;
        #1;
        check_val("pw4_async_clr", int'(dout[2]), 0);
        din[2] = 1'b0;
        step(2);
        rst_n = 1'b1;
        h0 = high_cnt[2];
        step(8);
        check_val("pw4_after_rst", high_cnt[2] - h0, 0);

        // Reset released with the input already high.
        rst_n = 1'b0;
        din[0] = 1'b1;
        step(2);
        rst_n = 1'b1;
        r0 = rise_cnt[0]; h0 = high_cnt[0]; c0 = cyc;
        step(10);
        check_val("rel_strobes", rise_cnt[0] - r0, 1);
        check_val("rel_width", high_cnt[0] - h0, 1);
        check_val("rel_latency", last_rise[0] - c0, 3);
        din[0] = 1'b0;
        step(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
